// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel produces a terminal-count
// strobe and an optional square wave; new settings are shadowed and applied only at a safe point.
module clk_div_multi #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 20,
    parameter int RESET_DIV = 9999,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] cfg_pending
);

    always_ff @(posedge clock) begin
        if (reset) cfg_ready <= 1'b0;
        else       cfg_ready <= 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_q, cnt_q, sh_div_q;
        logic             mode_q, en_q, sh_mode_q, sh_en_q, pend_q, tick_q, clk_q;
        logic             wr_hit, term, restart, apply, clk_d;

        // Shadow settings only land when the counter restarts from 0, so the
        // active divisor never changes underneath a running count.
        always_comb begin
            wr_hit  = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
            term    = en_q && !sync && (cnt_q == div_q);
            restart = sync || !en_q || term;
            apply   = pend_q && restart;
            clk_d   = clk_q;
            if (sync || !en_q)
                clk_d = 1'b0;
            else if (apply && (!sh_mode_q || !sh_en_q))
                clk_d = 1'b0;
            else if (term && mode_q)
                clk_d = !clk_q;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                div_q     <= CNT_W'(RESET_DIV);
                mode_q    <= 1'b1;
                en_q      <= 1'b1;
                cnt_q     <= '0;
                tick_q    <= 1'b0;
                clk_q     <= 1'b0;
                pend_q    <= 1'b0;
                sh_div_q  <= '0;
                sh_mode_q <= 1'b0;
                sh_en_q   <= 1'b0;
            end else begin
                if (apply) begin
                    div_q  <= sh_div_q;
                    mode_q <= sh_mode_q;
                    en_q   <= sh_en_q;
                end
                if (restart) cnt_q <= '0;
                else         cnt_q <= cnt_q + 1'b1;
                tick_q <= term;
                clk_q  <= clk_d;
                // A write arriving while the old shadow is being applied stays pending.
                if (wr_hit) begin
                    sh_div_q  <= cfg_div;
                    sh_mode_q <= cfg_mode;
                    sh_en_q   <= cfg_en;
                    pend_q    <= 1'b1;
                end else if (apply) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign tick[i]        = tick_q;
        assign clk_out[i]     = clk_q;
        assign cfg_pending[i] = pend_q;
    end

endmodule
